// File: rtl/iq_capture_buf.sv
// iq_capture_buf: records a DEPTH-sample I/Q window around a selectable trigger and reads it back by logical index.
// Optional feature macro IQ_CAP_SYMMARK_EN: store the symbol-tick flag with each sample and return it on rd_sym.
module iq_capture_buf #(
  parameter int DATA_W   = 12,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic [1:0]                 trig_mode,
  input  logic [DATA_W-2:0]          threshold,
  input  logic                       ext_trig,
  input  logic [DATA_W-1:0]          in_I,
  input  logic [DATA_W-1:0]          in_Q,
  input  logic                       in_valid,
  input  logic                       in_sym_tick,
  output logic [2:0]                 state_o,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   trig_addr,
  output logic [31:0]                sample_count,
  output logic [31:0]                sym_count,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_I,
  output logic [DATA_W-1:0]          rd_Q,
  output logic                       rd_sym,
  output logic                       rd_valid
);
  localparam int AW = $clog2(DEPTH);
`ifdef IQ_CAP_SYMMARK_EN
  localparam int WORD_W = 2*DATA_W + 1;
`else
  localparam int WORD_W = 2*DATA_W;
`endif
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [AW-1:0] PRE_LAST  = AW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
  localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRE_TRIG - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_pre_cnt;
  logic [AW-1:0]     r_post_cnt;
  logic [AW-1:0]     r_trig_addr;
  logic [31:0]       r_sample_count;
  logic [31:0]       r_sym_count;
  logic [DATA_W-1:0] w_mag;
  logic              w_src;
  logic              w_trig;
  logic              w_wr_en;
  logic              w_rd_go;
  logic [AW-1:0]     w_rd_phys;
  logic [WORD_W-1:0] w_wr_word;
  logic [WORD_W-1:0] r_rd_word;
  logic              r_rd_valid;
  logic [WORD_W-1:0] r_mem [DEPTH];

  // Magnitude is unsigned DATA_W bits, so the most negative input maps to 2^(DATA_W-1).
  assign w_mag = in_I[DATA_W-1] ? ((~in_I) + DATA_W'(1)) : in_I;

  always_comb begin
    w_src = 1'b0;
    case (trig_mode)
      2'd0:    w_src = 1'b1;
      2'd1:    w_src = in_sym_tick;
      2'd2:    w_src = (w_mag >= {1'b0, threshold});
      default: w_src = ext_trig;
    endcase
  end

  assign w_trig = in_valid && w_src;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (arm) begin
      w_state_next = (PRE_TRIG == 0) ? S_WAIT : S_PRE;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_IDLE;
        S_PRE:  if (in_valid && (r_pre_cnt == PRE_LAST)) w_state_next = S_WAIT;
        S_WAIT: if (w_trig) w_state_next = (POST_INIT == '0) ? S_DONE : S_CAP;
        S_CAP:  if (in_valid && (r_post_cnt == AW'(1))) w_state_next = S_DONE;
        S_DONE: w_state_next = S_DONE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state_o = r_state;
    done    = (r_state == S_DONE);
    w_wr_en = in_valid && !arm &&
              ((r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_CAP));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_pre_cnt      <= '0;
      r_post_cnt     <= '0;
      r_trig_addr    <= '0;
      r_sample_count <= '0;
      r_sym_count    <= '0;
    end else if (arm) begin
      r_wr_ptr       <= '0;
      r_pre_cnt      <= '0;
      r_sample_count <= '0;
      r_sym_count    <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (r_state == S_PRE && in_valid) r_pre_cnt <= r_pre_cnt + AW'(1);
      if (r_state == S_WAIT && w_trig) begin
        r_trig_addr <= r_wr_ptr;
        r_post_cnt  <= POST_INIT;
      end
      if (r_state == S_CAP && in_valid) r_post_cnt <= r_post_cnt - AW'(1);
      if (r_state != S_IDLE) begin
        if (in_valid && r_sample_count != 32'hFFFF_FFFF)
          r_sample_count <= r_sample_count + 32'd1;
        if (in_sym_tick && r_sym_count != 32'hFFFF_FFFF)
          r_sym_count <= r_sym_count + 32'd1;
      end
    end
  end

`ifdef IQ_CAP_SYMMARK_EN
  assign w_wr_word = {in_sym_tick, in_Q, in_I};
`else
  assign w_wr_word = {in_Q, in_I};
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_word;
  end

  // Logical index 0 is the oldest sample of the window, PRE_TRIG entries before the trigger.
  assign w_rd_phys = r_trig_addr - PRE_OFS + rd_addr;
  assign w_rd_go   = rd_en && !arm && (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_word  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_go;
      if (w_rd_go) r_rd_word <= r_mem[w_rd_phys];
    end
  end

  assign trig_addr    = r_trig_addr;
  assign sample_count = r_sample_count;
  assign sym_count    = r_sym_count;
  assign rd_I         = r_rd_word[DATA_W-1:0];
  assign rd_Q         = r_rd_word[2*DATA_W-1:DATA_W];
  assign rd_valid     = r_rd_valid;
`ifdef IQ_CAP_SYMMARK_EN
  assign rd_sym       = r_rd_word[2*DATA_W];
`else
  assign rd_sym       = 1'b0;
`endif

endmodule

// File: tb/tb_iq_capture_buf.sv
// Randomized bench for iq_capture_buf: a window model built from the list of samples since arm feeds a readback scoreboard.
module tb_iq_capture_buf;
  localparam int DW    = 12;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic [1:0]    trig_mode = 2'd0;
  logic [DW-2:0] threshold = '0;
  logic          ext_trig = 1'b0;
  logic [DW-1:0] in_I = '0;
  logic [DW-1:0] in_Q = '0;
  logic          in_valid = 1'b0;
  logic          in_sym_tick = 1'b0;
  logic [2:0]    state_o;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [31:0]   sample_count;
  logic [31:0]   sym_count;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_I;
  logic [DW-1:0] rd_Q;
  logic          rd_sym;
  logic          rd_valid;

  iq_capture_buf #(.DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig_mode(trig_mode), .threshold(threshold),
    .ext_trig(ext_trig), .in_I(in_I), .in_Q(in_Q), .in_valid(in_valid),
    .in_sym_tick(in_sym_tick), .state_o(state_o), .done(done), .trig_addr(trig_addr),
    .sample_count(sample_count), .sym_count(sym_count), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_I(rd_I), .rd_Q(rd_Q), .rd_sym(rd_sym), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] i; logic [DW-1:0] q; logic s; } smp_t;
  typedef struct { int cyc; logic [DW-1:0] i; logic [DW-1:0] q; logic s; } rd_exp_t;

  int      checks = 0;
  int      errors = 0;
  int      cyc_n = 0;
  rd_exp_t exp_q[$];
  smp_t    samples[$];
  bit      m_armed = 0;
  bit      m_done = 0;
  int      m_t = -1;
  int      m_taddr = 0;
  longint  m_scnt = 0;
  longint  m_ycnt = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic bit m_src();
    int v;
    case (trig_mode)
      2'd0: return 1'b1;
      2'd1: return in_sym_tick;
      2'd2: begin
        v = $signed(in_I);
        if (v < 0) v = -v;
        return v >= int'(threshold);
      end
      default: return ext_trig;
    endcase
  endfunction

  // Expected state follows from how far the sample list has progressed since arm.
  function automatic int m_state();
    if (!m_armed) return 0;
    if (m_done) return 4;
    if (m_t >= 0) return 3;
    if (samples.size() >= PRE) return 2;
    return 1;
  endfunction

  task automatic cyc();
    rd_exp_t e;
    smp_t    s;
    int      idx;
    if (rst_n && !arm && rd_en && m_done) begin
      idx   = m_t - PRE + int'(rd_addr);
      e.cyc = cyc_n + 1;
      e.i   = samples[idx].i;
      e.q   = samples[idx].q;
`ifdef IQ_CAP_SYMMARK_EN
      e.s   = samples[idx].s;
`else
      e.s   = 1'b0;
`endif
      exp_q.push_back(e);
    end
    if (!rst_n) begin
      m_armed = 0; m_done = 0; m_t = -1; m_taddr = 0; m_scnt = 0; m_ycnt = 0;
      samples.delete();
    end else if (arm) begin
      m_armed = 1; m_done = 0; m_t = -1; m_scnt = 0; m_ycnt = 0;
      samples.delete();
    end else if (m_armed) begin
      if (in_valid) m_scnt++;
      if (in_sym_tick) m_ycnt++;
      if (in_valid && !m_done) begin
        s.i = in_I; s.q = in_Q; s.s = in_sym_tick;
        samples.push_back(s);
        idx = samples.size() - 1;
        if (m_t < 0 && idx >= PRE && m_src()) begin
          m_t = idx;
          m_taddr = idx % DEPTH;
        end
        if (m_t >= 0 && samples.size() == m_t + DEPTH - PRE) m_done = 1;
      end
    end
    @(posedge clk);
    cyc_n++;
    #1;
    chk("state", 64'(state_o), 64'(m_state()));
    chk("done", 64'(done), 64'(m_state() == 4));
    chk("trig_addr", 64'(trig_addr), 64'(m_taddr));
    chk("sample_count", 64'(sample_count), m_scnt);
    chk("sym_count", 64'(sym_count), m_ycnt);
    arm = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic read_window(int n, int start);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      rd_addr = AW'((start + i) % DEPTH);
      in_valid = 1'($urandom_range(0, 1));
      in_I = DW'($urandom); in_Q = DW'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();
  endtask

  always @(negedge clk) begin : monitor
    rd_exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc_n) begin
      checks++; errors++;
      $display("FAIL rd_missing actual=no_rd_valid required=rd_valid_at_cycle_%0d", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected actual=rd_valid=1 required=rd_valid=0 cycle=%0d", cyc_n);
      end else begin
        e = exp_q.pop_front();
        chk("rd_latency", 64'(cyc_n), 64'(e.cyc));
        chk("rd_I", 64'(rd_I), 64'(e.i));
        chk("rd_Q", 64'(rd_Q), 64'(e.q));
        chk("rd_sym", 64'(rd_sym), 64'(e.s));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [DW-1:0] hold_i;
    int vc, ticks, n;

    repeat (3) cyc();
    chk("rst_rd_I", 64'(rd_I), 0);
    chk("rst_rd_Q", 64'(rd_Q), 0);
    chk("rst_rd_sym", 64'(rd_sym), 0);
    chk("rst_rd_valid", 64'(rd_valid), 0);
    rst_n = 1'b1;
    cyc();

    // Immediate trigger on a ramp
    trig_mode = 2'd0; arm = 1'b1; cyc();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_I = DW'(k); in_Q = DW'(-k);
      cyc();
      if (k == 4) chk("t1_trig_state", 64'(state_o), 3);
      if (k == 15) chk("t1_done", 64'(done), 1);
    end
    in_valid = 1'b0;
    chk("t1_trig_addr", 64'(trig_addr), 4);
    read_window(16, 0);

    // Threshold trigger with wrap, plus a gated read while waiting
    trig_mode = 2'd2; threshold = 11'd100; arm = 1'b1; cyc();
    for (int k = 0; k < 22; k++) begin
      in_valid = 1'b1; in_I = DW'(10 * k); in_Q = DW'($urandom);
      cyc();
      if (k == 6) begin
        hold_i = rd_I;
        in_valid = 1'b0; rd_en = 1'b1; rd_addr = 4'd3;
        cyc();
        chk("gated_rd_valid", 64'(rd_valid), 0);
        chk("gated_rd_hold", 64'(rd_I), 64'(hold_i));
      end
    end
    in_valid = 1'b0;
    chk("t2_trig_addr", 64'(trig_addr), 10);
    chk("t2_done", 64'(done), 1);
    read_window(16, 0);

    // Symbol-tick trigger with sparse valid
    trig_mode = 2'd1; arm = 1'b1; cyc();
    vc = 0; ticks = 0;
    for (int c = 0; c < 4000 && !m_done; c++) begin
      in_valid = (c % 4 == 0);
      in_sym_tick = in_valid && (vc % 16 == 15);
      if (in_valid) vc++;
      if (in_sym_tick) ticks++;
      in_I = DW'($urandom); in_Q = DW'($urandom);
      cyc();
    end
    in_valid = 1'b0; in_sym_tick = 1'b0;
    chk("t3_done", 64'(done), 1);
    chk("t3_trig_addr", 64'(trig_addr), 15);
    chk("t3_sym_count", 64'(sym_count), 64'(ticks));
    read_window(16, 0);

    // Most negative input always passes the magnitude test
    trig_mode = 2'd2; threshold = 11'd2047; arm = 1'b1; cyc();
    for (int c = 0; c < 200 && !m_done; c++) begin
      in_valid = 1'b1;
      in_I = (c == 10) ? 12'h800 : DW'(int'($urandom_range(0, 4000)) - 2000);
      in_Q = DW'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    chk("t4_done", 64'(done), 1);
    chk("t4_trig_addr", 64'(trig_addr), 10);
    read_window(8, $urandom_range(0, DEPTH - 1));

    // arm beats rd_en in the same cycle
    rd_en = 1'b1; rd_addr = 4'd0; arm = 1'b1; cyc();
    chk("arm_rd_valid", 64'(rd_valid), 0);

    // Randomized captures over all trigger sources
    for (int it = 0; it < 6; it++) begin
      trig_mode = 2'($urandom_range(0, 3));
      threshold = 11'($urandom_range(500, 2047));
      arm = 1'b1; in_valid = 1'($urandom_range(0, 1)); cyc();
      for (int c = 0; c < 3000 && !m_done; c++) begin
        in_valid = 1'($urandom_range(0, 1));
        ext_trig = ($urandom_range(0, 9) == 0);
        in_sym_tick = ($urandom_range(0, 7) == 0);
        in_I = DW'($urandom); in_Q = DW'($urandom);
        cyc();
      end
      ext_trig = 1'b0; in_sym_tick = 1'b0; in_valid = 1'b0;
      chk("rand_done", 64'(done), 1);
      n = 0;
      for (int j = 0; j < 12; j++) begin
        rd_en = ($urandom_range(0, 3) != 0);
        rd_addr = AW'($urandom);
        cyc();
      end
      cyc(); cyc();
    end

    // Re-arm during CAP
    trig_mode = 2'd0; arm = 1'b1; cyc();
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1; in_I = DW'(k); in_Q = DW'(k);
      cyc();
    end
    chk("cap_state", 64'(state_o), 3);
    arm = 1'b1; in_valid = 1'b1; in_sym_tick = 1'b1;
    cyc();
    in_sym_tick = 1'b0;
    chk("rearm_state", 64'(state_o), 1);
    chk("rearm_samples", 64'(sample_count), 0);
    chk("rearm_syms", 64'(sym_count), 0);

    // Reset during WAIT
    trig_mode = 2'd1; arm = 1'b1; in_valid = 1'b0; cyc();
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; cyc();
    end
    chk("wait_state", 64'(state_o), 2);
    rst_n = 1'b0; arm = 1'b1; cyc();
    chk("rst_state", 64'(state_o), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_rd_valid2", 64'(rd_valid), 0);
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (3) cyc();

    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
